unsign_multiplier_seq: RTL and testbench
========================================

# unsign_multiplier_seq

Sequential unsigned shift-and-add multiplier: the inverse arithmetic operation to the combinational unsigned divider, sharing its operand width parameter and unsigned semantics. Accepts two `INPUT_BIT_WIDTH`-bit operands on a start pulse and produces a full `2*INPUT_BIT_WIDTH`-bit product after a fixed `INPUT_BIT_WIDTH`-cycle iteration. It also serves as a golden-check companion for divider benches: `Quotient*Divider + Remainder` must equal `Dividend`.

## Interface
- `INPUT_BIT_WIDTH`, default 8: operand width, must be ≥ 2; product width is `2*INPUT_BIT_WIDTH`.

Ports:
- `Clk`  input  1: single clock; all state changes on its rising edge.
- `Reset`  input  1: asynchronous, active-high reset.
- `Start`  input  1: request to begin a multiply; sampled on the rising edge of `Clk`.
- `Multiplicand`  input  `INPUT_BIT_WIDTH`: unsigned operand A; captured when `Start` is accepted.
- `Multiplier`  input  `INPUT_BIT_WIDTH`: unsigned operand B; captured when `Start` is accepted.
- `Busy`  output  1: high while iterating (RUN state).
- `Done`  output  1: one-cycle pulse when `Product` has just been updated.
- `Product`  output  `2*INPUT_BIT_WIDTH`: registered result A*B; holds its value until the next completion.

## Operation
- States:
  - IDLE: waiting for a start request.
  - RUN: iterating.
  - DONE: result valid; `Done` is high.
- IDLE, `Start`=1 → RUN. On that edge:
  - capture Multiplicand zero-extended to 2W into `mcand`;
  - capture Multiplier into `mplier`;
  - clear `acc` (2W bits);
  - clear the iteration counter.
- RUN, each edge:
  - if `mplier[0]`, then `acc <= acc + mcand`; the addition is exact at 2W bits and never overflows;
  - `mcand <= mcand << 1`;
  - `mplier <= mplier >> 1`;
  - counter increments.
- On the W-th RUN edge, the final accumulated value is written directly into `Product`, and the state moves to DONE.
- DONE → IDLE on the next edge if `Start`=0.
- DONE with `Start`=1 → RUN, capturing the new operands. This gives back-to-back operation with no idle gap.
- `Start` in RUN is ignored. Operands changing after capture do not affect the result.
- A start request is accepted exactly when `Busy`=0 and the state is IDLE or DONE.
- Latency is fixed at W iterations regardless of operand values; there is no early termination.
- Reset (asynchronous, any state, including mid-RUN):
  - state → IDLE; the current operation is abandoned;
  - `Busy`=0, `Done`=0, `Product`=0;
  - `acc`, `mcand`, `mplier` and the counter are all cleared.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Product`=0.
- Start accepted at edge k:
  - `Busy`=1 from edge k through edge k+W;
  - at edge k+W, `Product` is updated, `Done`=1 and `Busy`=0;
  - at edge k+W+1, `Done`=0 unless a new result completes on that edge.
- Throughput: one result per W+1 cycles when `Start` is held high continuously.
- `Done` is high for exactly one cycle per completed operation.
- `Product` changes only on a completion edge or on reset.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Reset deassertion must be synchronous to `Clk`. That is the integrator's concern; the block itself adds no synchronizer.

## Structure
- Shared include `unsign_arith_defs.vh` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - a `CLOG2`-style counter-width macro, also reusable by a future sequential divider.
- Counter width is `$clog2(INPUT_BIT_WIDTH+1)`.
- Single module, no sub-module. The control FSM and the shift-add datapath are small enough to stay together; splitting out a datapath adds ports for no reuse.

## Test plan
- Reset, then `Multiplicand`=13, `Multiplier`=2, one-cycle `Start`:
  - `Busy` is high for 8 cycles;
  - `Done` pulses on the 8th edge after start, with `Product`=26;
  - `Product` still reads 26 ten cycles later.
- Bounds: 255*255 → `Product`=65025 (0xFE01). 0*200 → 0. 1*255 → 255. In each case `Done` comes exactly 8 cycles after start.
- `Start` held high continuously with operands 13,2 then 7,9:
  - `Done` pulses every 9 cycles;
  - the products are 26 then 63.
- `Start` pulsed during RUN with different operands: ignored; the current result and its timing are unchanged.
- Operands changed on the cycle after start: the result reflects the captured values only.
- `Reset` asserted asynchronously between edges, 4 cycles into a 200*3 operation:
  - `Busy`, `Done` and `Product` go to 0 immediately, without waiting for an edge;
  - after release, a new 5*5 operation gives 25 with normal 8-cycle latency.
- Random sweep, at least 1000 operand pairs at W=8 plus one run at W=16: `Product` == A*B for every pair.

Source files
------------

// File: rtl/unsign_multiplier_seq_pkg.sv
// Shared definitions for the sequential unsigned arithmetic blocks: FSM states and
// counter sizing.
package unsign_multiplier_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bits needed for a counter that must be able to hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/unsign_multiplier_seq_if.sv
// Request/result bundle for the sequential unsigned multiplier.
interface unsign_multiplier_seq_if #(
  parameter int unsigned INPUT_BIT_WIDTH = 8
);
  logic                           Start;
  logic [INPUT_BIT_WIDTH-1:0]     Multiplicand;
  logic [INPUT_BIT_WIDTH-1:0]     Multiplier;
  logic                           Busy;
  logic                           Done;
  logic [2*INPUT_BIT_WIDTH-1:0]   Product;

  modport master (
    output Start, Multiplicand, Multiplier,
    input  Busy, Done, Product
  );

  modport slave (
    input  Start, Multiplicand, Multiplier,
    output Busy, Done, Product
  );
endinterface

// File: rtl/unsign_multiplier_seq.sv
// Shift-and-add unsigned multiplier: fixed INPUT_BIT_WIDTH iterations per product,
// back-to-back starts accepted from the DONE state.
module unsign_multiplier_seq
  import unsign_multiplier_seq_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  unsign_multiplier_seq_if.slave bus
);

  localparam int unsigned W  = INPUT_BIT_WIDTH;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = cnt_width(W);

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic [PW-1:0]   acc_sum;
  logic            last_iter;

  always_comb begin
    acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_iter = (cnt_q == CW'(W - 1));

    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.Start) begin
          state_d  = StRun;
          mcand_d  = PW'(bus.Multiplicand);
          mplier_d = bus.Multiplier;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Final partial product goes straight to the output register.
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.Busy    = (state_q == StRun);
  assign bus.Done    = (state_q == StDone);
  assign bus.Product = product_q;

endmodule

// File: tb/tb_unsign_multiplier_seq.sv
// Self-checking bench for unsign_multiplier_seq at W=8 and W=16 against plain A*B
// with a fixed W-cycle latency.
module tb_unsign_multiplier_seq;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  unsign_multiplier_seq_if #(.INPUT_BIT_WIDTH(8))  bus8 ();
  unsign_multiplier_seq_if #(.INPUT_BIT_WIDTH(16)) bus16 ();

  unsign_multiplier_seq #(.INPUT_BIT_WIDTH(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8)
  );

  unsign_multiplier_seq #(.INPUT_BIT_WIDTH(16)) dut16 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus16)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Called just after the accepting edge; cyc = edges until Done, -1 on timeout.
  task automatic wait_done8(output int cyc, output int busy_cyc, output logic [15:0] p);
    cyc      = -1;
    busy_cyc = bus8.Busy ? 1 : 0;
    p        = '0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus8.Done) begin
        cyc = i;
        p   = bus8.Product;
        break;
      end
      if (bus8.Busy) busy_cyc++;
    end
  endtask

  task automatic wait_done16(output int cyc, output logic [31:0] p);
    cyc = -1;
    p   = '0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (bus16.Done) begin
        cyc = i;
        p   = bus16.Product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus8.Start = 1'b0;  bus8.Multiplicand = '0;  bus8.Multiplier = '0;
    bus16.Start = 1'b0; bus16.Multiplicand = '0; bus16.Multiplier = '0;
    step();
    step();
    checks += 4;
    if (bus8.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus8.Busy); end
    if (bus8.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus8.Done); end
    if (bus8.Product !== 16'd0) begin
      errors++; $display("FAIL reset_product got %0d want 0", bus8.Product);
    end
    if (bus16.Product !== 32'd0) begin
      errors++; $display("FAIL reset_product16 got %0d want 0", bus16.Product);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic [15:0] p;
    bus8.Multiplicand = 8'd13; bus8.Multiplier = 8'd2; bus8.Start = 1'b1;
    step();
    bus8.Start = 1'b0;
    wait_done8(cyc, bc, p);
    checks += 3;
    if (cyc != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", cyc); end
    if (bc != 8)  begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    if (p !== 16'd26) begin errors++; $display("FAIL basic_product got %0d want 26", p); end
    step();
    checks++;
    if (bus8.Done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus8.Done); end
    repeat (9) step();
    checks++;
    if (bus8.Product !== 16'd26) begin
      errors++; $display("FAIL basic_hold got %0d want 26", bus8.Product);
    end
  endtask

  task automatic test_bounds();
    logic [7:0] a_t [3];
    logic [7:0] b_t [3];
    int cyc, bc;
    logic [15:0] p, exp;
    a_t = '{8'd255, 8'd0, 8'd1};
    b_t = '{8'd255, 8'd200, 8'd255};
    for (int i = 0; i < 3; i++) begin
      exp = 16'(int'(a_t[i]) * int'(b_t[i]));
      bus8.Multiplicand = a_t[i]; bus8.Multiplier = b_t[i]; bus8.Start = 1'b1;
      step();
      bus8.Start = 1'b0;
      wait_done8(cyc, bc, p);
      checks += 2;
      if (p !== exp) begin
        errors++; $display("FAIL bounds_product %0d*%0d got %0d want %0d", a_t[i], b_t[i], p, exp);
      end
      if (cyc != 8) begin errors++; $display("FAIL bounds_latency got %0d want 8", cyc); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [15:0] p;
    bus8.Multiplicand = 8'd13; bus8.Multiplier = 8'd2; bus8.Start = 1'b1;
    step();
    bus8.Multiplicand = 8'd7; bus8.Multiplier = 8'd9;
    wait_done8(cyc, bc, p);
    checks += 2;
    if (cyc != 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", cyc); end
    if (p !== 16'd26) begin errors++; $display("FAIL b2b_first_product got %0d want 26", p); end
    wait_done8(cyc, bc, p);
    bus8.Start = 1'b0;
    checks += 2;
    if (cyc != 9) begin errors++; $display("FAIL b2b_period got %0d want 9", cyc); end
    if (p !== 16'd63) begin errors++; $display("FAIL b2b_second_product got %0d want 63", p); end
    step();
    checks++;
    if (bus8.Done !== 1'b0 || bus8.Busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got done=%b busy=%b want 0 0", bus8.Done, bus8.Busy);
    end
  endtask

  task automatic test_start_during_run();
    int cyc;
    logic [15:0] p;
    cyc = -1;
    p   = '0;
    bus8.Multiplicand = 8'd100; bus8.Multiplier = 8'd3; bus8.Start = 1'b1;
    step();
    bus8.Start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin
        bus8.Start = 1'b1; bus8.Multiplicand = 8'd5; bus8.Multiplier = 8'd5;
      end
      if (i == 4) bus8.Start = 1'b0;
      step();
      if (bus8.Done) begin
        cyc = i;
        p   = bus8.Product;
        break;
      end
    end
    checks += 2;
    if (cyc != 8) begin errors++; $display("FAIL run_start_latency got %0d want 8", cyc); end
    if (p !== 16'd300) begin errors++; $display("FAIL run_start_product got %0d want 300", p); end
    step();
    checks++;
    if (bus8.Busy !== 1'b0) begin errors++; $display("FAIL run_start_restart got busy=%b want 0", bus8.Busy); end
  endtask

  task automatic test_operand_change();
    int cyc, bc;
    logic [15:0] p;
    bus8.Multiplicand = 8'd17; bus8.Multiplier = 8'd11; bus8.Start = 1'b1;
    step();
    bus8.Start = 1'b0;
    bus8.Multiplicand = 8'd0; bus8.Multiplier = 8'd255;
    wait_done8(cyc, bc, p);
    checks++;
    if (p !== 16'd187) begin errors++; $display("FAIL operand_change got %0d want 187", p); end
    step();
  endtask

  task automatic test_async_reset();
    int cyc, bc;
    logic [15:0] p;
    bus8.Multiplicand = 8'd200; bus8.Multiplier = 8'd3; bus8.Start = 1'b1;
    step();
    bus8.Start = 1'b0;
    repeat (4) step();
    checks++;
    if (bus8.Busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b want 1", bus8.Busy); end
    #2;
    Reset = 1'b1;
    #1;
    checks += 3;
    if (bus8.Busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", bus8.Busy); end
    if (bus8.Done !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", bus8.Done); end
    if (bus8.Product !== 16'd0) begin
      errors++; $display("FAIL areset_product got %0d want 0", bus8.Product);
    end
    #2;
    Reset = 1'b0;
    step();
    bus8.Multiplicand = 8'd5; bus8.Multiplier = 8'd5; bus8.Start = 1'b1;
    step();
    bus8.Start = 1'b0;
    wait_done8(cyc, bc, p);
    checks += 2;
    if (p !== 16'd25) begin errors++; $display("FAIL areset_after_product got %0d want 25", p); end
    if (cyc != 8) begin errors++; $display("FAIL areset_after_latency got %0d want 8", cyc); end
    step();
  endtask

  task automatic test_random();
    int cyc, bc;
    logic [15:0] p;
    logic [31:0] p32;
    int unsigned a, b;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      bus8.Multiplicand = 8'(a); bus8.Multiplier = 8'(b); bus8.Start = 1'b1;
      step();
      bus8.Start = 1'b0;
      wait_done8(cyc, bc, p);
      checks++;
      if (p !== 16'(a * b) || cyc != 8) begin
        errors++;
        $display("FAIL rand8 %0d*%0d got %0d lat %0d want %0d lat 8", a, b, p, cyc, a * b);
      end
    end
    for (int n = 0; n < 200; n++) begin
      a = (n == 0) ? 32'd65535 : $urandom_range(0, 65535);
      b = (n == 0) ? 32'd65535 : $urandom_range(0, 65535);
      bus16.Multiplicand = 16'(a); bus16.Multiplier = 16'(b); bus16.Start = 1'b1;
      step();
      bus16.Start = 1'b0;
      wait_done16(cyc, p32);
      checks++;
      if (p32 !== 32'(longint'(a) * longint'(b)) || cyc != 16) begin
        errors++;
        $display("FAIL rand16 %0d*%0d got %0d lat %0d want %0d lat 16", a, b, p32, cyc,
                 longint'(a) * longint'(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_back_to_back();
    test_start_during_run();
    test_operand_change();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
